// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl: D-stage HI/LO hazard stall with a shadow busy counter for the mult/div unit.
// Define MD_BUSY_CHECK_EN to add the sticky shadow-vs-unit busy mismatch flag md_err.
module md_hazard_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_D,
  input  logic md_is_div_D,
  input  logic md_access_D,
  input  logic stall_other,
  input  logic flush_E,
  input  logic busy_E,
  output logic stall_D,
  output logic start_pend_E,
  output logic busy_shadow,
  output logic md_err
);
  logic       start_pend_q, start_pend_d;
  logic       pend_div_q, pend_div_d;
  logic [3:0] cnt_q, cnt_d;
  logic       issue;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      start_pend_q <= 1'b0;
      pend_div_q   <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      start_pend_q <= start_pend_d;
      pend_div_q   <= pend_div_d;
      cnt_q        <= cnt_d;
    end
  // A flushed start never loads the counter; otherwise the counter free-runs down to 0.
  always_comb begin
    issue        = md_start_D & ~stall_D & ~stall_other;
    start_pend_d = issue;
    pend_div_d   = issue ? md_is_div_D : pend_div_q;
    cnt_d        = (start_pend_q & ~flush_E) ? (pend_div_q ? 4'(DIV_LAT) : 4'(MULT_LAT))
                 : (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  end
  always_comb begin
    start_pend_E = start_pend_q;
    busy_shadow  = cnt_q != 4'd0;
    stall_D      = (md_start_D | md_access_D) & (start_pend_q | busy_shadow);
  end
`ifdef MD_BUSY_CHECK_EN
  logic md_err_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) md_err_q <= 1'b0;
    else if (busy_shadow != busy_E) md_err_q <= 1'b1;
  assign md_err = md_err_q;
`else
  logic unused_busy_e;
  assign unused_busy_e = busy_E;
  assign md_err = 1'b0;
`endif
endmodule
